combat_resolver: RTL
====================

// Module: combat_resolver
// PURPOSE
//  Parametrised, clocked successor to the two-player hit/health logic.
//  Resolves melee and fireball hits among NUM_PLAYERS fighters each clk.
//  Tracks saturating health with post-hit invulnerability and one-hit-per-swing melee.
//  Declares the round winner. Sits between the player/fireball movers and the HUD/sprite renderer.
// PARAMETERS
//  NUM_PLAYERS    2    fighters (2..4); index p = 0..NUM_PLAYERS-1
//  COORD_W        10   x/y coordinate width
//  HEALTH_W       7    health width
//  MAX_HEALTH     40   health after reset/round restart (< 2**HEALTH_W)
//  MELEE_DMG      2    damage per landed melee swing
//  FIREBALL_DMG   5    damage per fireball hit
//  INVULN_CYCLES  16   cycles a player ignores damage after being hit (0 = none)
// PORTS
//  clk             in   1                    system clock
//  reset_n         in   1                    async active-low reset
//  round_restart   in   1                    sync pulse: start new round
//  player_x        in   NUM_PLAYERS*COORD_W  packed; player p at [p*COORD_W +: COORD_W]
//  player_y        in   NUM_PLAYERS*COORD_W  feet y (sprite bottom)
//  player_state    in   NUM_PLAYERS*3        combat_pkg state codes
//  fireball_x      in   NUM_PLAYERS*COORD_W  fireball owned by player p
//  fireball_y      in   NUM_PLAYERS*COORD_W
//  fireball_valid  in   NUM_PLAYERS          fireball p in flight
//  fireball_hit    out  NUM_PLAYERS          1-cycle pulse: fireball p landed; mover retires it
//  player_hit      out  NUM_PLAYERS          1-cycle pulse: damage applied to p
//  player_health   out  NUM_PLAYERS*HEALTH_W current health
//  game_over       out  1                    round ended, sticky until restart
//  winner          out  $clog2(NUM_PLAYERS)+1 survivor index; all-ones = draw
// BEHAVIOUR
//  Reset (async) and round_restart (sync; wins over all hits in the same cycle):
//   health = MAX_HEALTH; pulses, game_over, invuln counters and melee_spent = 0;
//   winner = all-ones.
//  Geometry: compare in signed COORD_W+2 bits. No unsigned wrap: a window edge < 0 clamps to 0.
//  Overlap, attacker a -> target t (a != t; self-hits never count):
//   melee   = state[a]==MELEE_RIGHT && y[t]==y[a] && x[a] <= x[t] <= x[a]+SPRITE_WIDTH+2,
//             or state[a]==MELEE_LEFT && y[t]==y[a] && x[a]-SPRITE_WIDTH-2 <= x[t] <= x[a],
//             and !melee_spent[a]
//   fire    = fireball_valid[a] && state[t]!=CROUCH && |fx[a]-x[t]| <= SPRITE_WIDTH/2+1
//             && y[t]-SPRITE_HEIGHT+1 <= fy[a] <= y[t]
//   Crouch blocks fireballs only, not melee.
//  Per edge, when !game_over, for each target t:
//   dmg = sum over attackers of (melee ? MELEE_DMG : 0) + (fire ? FIREBALL_DMG : 0).
//   Sum in HEALTH_W+3 bits.
//   If dmg != 0 and invuln[t] == 0: health -= dmg, saturating at 0; player_hit[t] = 1;
//   invuln[t] = INVULN_CYCLES. Otherwise invuln[t] decrements to 0.
//  Latency: 1 cycle from inputs to player_hit, health and fireball_hit.
//  fireball_hit[a]: pulses when any fire(a,t) overlap holds, even if t is invulnerable.
//  melee_spent[a]: set on the edge a melee(a,t) overlap holds. Cleared when state[a] leaves both MELEE states.
//  Game end: on the edge any health reaches 0, game_over = 1.
//   winner = the single nonzero-health index, or all-ones if 0 or >1 remain.
//  While game_over: health frozen, all pulses held 0, overlaps ignored until restart.
//  All outputs are registered; no combinational path from inputs to outputs.
// STRUCTURE
//  combat_pkg: state codes (MELEE_STATE_RIGHT/LEFT, CROUCH_STATE), SPRITE_WIDTH/HEIGHT,
//   and a fighter_pos_t struct. It replaces the textual globals include.
//  Sub-module health_channel (one per player via generate):
//   takes the dmg vector and game_over; holds health, invuln counter and hit pulse.
//  Top level: pairwise overlap generate loops, melee_spent flags, winner encoder.
// TESTING
//  1 Reset, then idle 5 cycles -> health all 40, game_over=0, winner=all-ones, no pulses.
//  2 P0 MELEE_RIGHT x=100 y=200; P1 x=120 y=200; held 40 cycles
//    -> exactly one player_hit[1], health1=38.
//    P0 leaves melee, then re-enters after invuln expires -> health1=36.
//  3 fireball0 (110,190) valid; P1 x=110 y=200 standing -> fireball_hit[0]=1, health1=35.
//    Same case with P1 CROUCH -> no pulse, health unchanged.
//  4 P1 health 3, fireball hit -> health1=0 (saturate), game_over=1, winner=0.
//    Further hits -> no change.
//  5 P0 and P1 both at health 2 trade melee on the same edge -> both 0, game_over=1, winner=all-ones (draw).
//  6 round_restart asserted together with a hit -> health 40, no pulse.
//    Also: reset_n dropped mid-invuln -> counters cleared, next hit lands at once.

Source files
------------

// File: rtl/combat_pkg.sv
// Shared fighter definitions for the combat resolver: state codes,
// sprite geometry and the signed position record used for hit windows.
package combat_pkg;

  typedef enum logic [2:0] {
    IDLE_STATE        = 3'd0,
    WALK_STATE        = 3'd1,
    JUMP_STATE        = 3'd2,
    CROUCH_STATE      = 3'd3,
    MELEE_STATE_RIGHT = 3'd4,
    MELEE_STATE_LEFT  = 3'd5
  } fighter_state_e;

  // Positions are carried signed and wide enough that window edges never wrap
  // for any coordinate width up to 14 bits.
  localparam int unsigned POS_W = 16;
  typedef logic signed [POS_W-1:0] pos_t;

  localparam pos_t SPRITE_WIDTH  = 16'sd32;
  localparam pos_t SPRITE_HEIGHT = 16'sd48;

  // Derived window sizes.
  localparam pos_t MELEE_REACH = SPRITE_WIDTH + 16'sd2;
  localparam pos_t FIRE_HALF_W = (SPRITE_WIDTH / 16'sd2) + 16'sd1;
  localparam pos_t FIRE_SPAN_H = SPRITE_HEIGHT - 16'sd1;

  typedef struct packed {
    pos_t x;
    pos_t y;
  } fighter_pos_t;

  // Window edges below the playfield clamp to zero.
  function automatic pos_t clamp0(input pos_t v);
    return v[POS_W-1] ? '0 : v;
  endfunction

  function automatic pos_t abs_pos(input pos_t v);
    return v[POS_W-1] ? -v : v;
  endfunction

endpackage

// File: rtl/health_channel.sv
// Per-fighter health tracker: applies the summed damage of one edge with
// saturation at zero, then ignores damage for INVULN_CYCLES cycles.
module health_channel
  import combat_pkg::*;
#(
  parameter int unsigned HEALTH_W      = 7,
  parameter int unsigned DMG_W         = 10,
  parameter int unsigned MAX_HEALTH    = 40,
  parameter int unsigned INVULN_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                round_restart_i,
  input  logic [DMG_W-1:0]    dmg_i,
  input  logic                game_over_i,
  output logic [HEALTH_W-1:0] health_o,
  output logic [HEALTH_W-1:0] health_next_o,
  output logic                hit_o
);

  localparam int unsigned IW = (INVULN_CYCLES > 0) ? $clog2(INVULN_CYCLES + 1) : 1;

  logic [HEALTH_W-1:0] health_q, health_d;
  logic [IW-1:0]       invuln_q, invuln_d;
  logic                hit_q, hit_d;

  // Damage lands only when vulnerable; otherwise the invulnerability window counts down.
  always_comb begin
    health_d = health_q;
    invuln_d = invuln_q;
    hit_d    = 1'b0;
    if (!game_over_i) begin
      if ((dmg_i != '0) && (invuln_q == '0)) begin
        health_d = (dmg_i >= DMG_W'(health_q)) ? '0 : health_q - HEALTH_W'(dmg_i);
        hit_d    = 1'b1;
        invuln_d = IW'(INVULN_CYCLES);
      end else if (invuln_q != '0) begin
        invuln_d = invuln_q - IW'(1);
      end
    end
  end

  // Health, invulnerability counter and hit pulse registers; restart wins over damage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      health_q <= HEALTH_W'(MAX_HEALTH);
      invuln_q <= '0;
      hit_q    <= 1'b0;
    end else if (round_restart_i) begin
      health_q <= HEALTH_W'(MAX_HEALTH);
      invuln_q <= '0;
      hit_q    <= 1'b0;
    end else begin
      health_q <= health_d;
      invuln_q <= invuln_d;
      hit_q    <= hit_d;
    end
  end

  assign health_o      = health_q;
  assign health_next_o = health_d;
  assign hit_o         = hit_q;

endmodule

// File: rtl/combat_resolver.sv
// Resolves melee and fireball hits among NUM_PLAYERS fighters each clock,
// tracks health per fighter and declares the round winner.
module combat_resolver
  import combat_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS   = 2,
  parameter int unsigned COORD_W       = 10,
  parameter int unsigned HEALTH_W      = 7,
  parameter int unsigned MAX_HEALTH    = 40,
  parameter int unsigned MELEE_DMG     = 2,
  parameter int unsigned FIREBALL_DMG  = 5,
  parameter int unsigned INVULN_CYCLES = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            round_restart,
  input  logic [NUM_PLAYERS*COORD_W-1:0]  player_x,
  input  logic [NUM_PLAYERS*COORD_W-1:0]  player_y,
  input  logic [NUM_PLAYERS*3-1:0]        player_state,
  input  logic [NUM_PLAYERS*COORD_W-1:0]  fireball_x,
  input  logic [NUM_PLAYERS*COORD_W-1:0]  fireball_y,
  input  logic [NUM_PLAYERS-1:0]          fireball_valid,
  output logic [NUM_PLAYERS-1:0]          fireball_hit,
  output logic [NUM_PLAYERS-1:0]          player_hit,
  output logic [NUM_PLAYERS*HEALTH_W-1:0] player_health,
  output logic                            game_over,
  output logic [$clog2(NUM_PLAYERS):0]    winner
);

  localparam int unsigned NP    = NUM_PLAYERS;
  localparam int unsigned WIN_W = $clog2(NUM_PLAYERS) + 1;
  localparam int unsigned CNT_W = WIN_W + 1;
  localparam int unsigned DMG_W = HEALTH_W + 3;
  localparam int unsigned PAD_W = POS_W - COORD_W;

  fighter_pos_t  pos  [NP];
  fighter_pos_t  fpos [NP];
  logic [2:0]    state [NP];

  logic [NP*NP-1:0] melee_ov;   // bit a*NP+t: attacker a melee-overlaps target t
  logic [NP*NP-1:0] fire_ov;    // bit a*NP+t: fireball a overlaps target t

  logic [DMG_W-1:0]    dmg         [NP];
  logic [HEALTH_W-1:0] health_cur  [NP];
  logic [HEALTH_W-1:0] health_next [NP];

  logic [NP-1:0]    melee_spent_q, melee_spent_d;
  logic [NP-1:0]    fireball_hit_q, fireball_hit_d;
  logic             game_over_q, game_over_d;
  logic [WIN_W-1:0] winner_q, winner_d;

  logic             any_dead;
  logic [CNT_W-1:0] alive_cnt;
  logic [WIN_W-1:0] alive_idx;

  // Unpack the flat input buses into signed per-fighter records.
  always_comb begin
    for (int unsigned p = 0; p < NP; p++) begin
      pos[p].x  = pos_t'({{PAD_W{1'b0}}, player_x[p*COORD_W +: COORD_W]});
      pos[p].y  = pos_t'({{PAD_W{1'b0}}, player_y[p*COORD_W +: COORD_W]});
      fpos[p].x = pos_t'({{PAD_W{1'b0}}, fireball_x[p*COORD_W +: COORD_W]});
      fpos[p].y = pos_t'({{PAD_W{1'b0}}, fireball_y[p*COORD_W +: COORD_W]});
      state[p]  = player_state[p*3 +: 3];
    end
  end

  for (genvar a = 0; a < NP; a++) begin : g_att
    for (genvar t = 0; t < NP; t++) begin : g_tgt
      if (a == t) begin : g_self
        assign melee_ov[a*NP+t] = 1'b0;
        assign fire_ov[a*NP+t]  = 1'b0;
      end else begin : g_pair
        logic melee_r, melee_l, fire_x, fire_y;
        assign melee_r = (state[a] == MELEE_STATE_RIGHT)
                      && (pos[t].x >= pos[a].x) && (pos[t].x <= pos[a].x + MELEE_REACH);
        assign melee_l = (state[a] == MELEE_STATE_LEFT)
                      && (pos[t].x >= clamp0(pos[a].x - MELEE_REACH)) && (pos[t].x <= pos[a].x);
        assign melee_ov[a*NP+t] = (melee_r || melee_l) && (pos[t].y == pos[a].y)
                               && !melee_spent_q[a];
        assign fire_x = abs_pos(fpos[a].x - pos[t].x) <= FIRE_HALF_W;
        assign fire_y = (fpos[a].y >= clamp0(pos[t].y - FIRE_SPAN_H)) && (fpos[a].y <= pos[t].y);
        assign fire_ov[a*NP+t] = fireball_valid[a] && (state[t] != CROUCH_STATE)
                              && fire_x && fire_y;
      end
    end
  end

  // Sum every attacker's contribution per target, and derive fireball and swing flags.
  always_comb begin
    for (int unsigned t = 0; t < NP; t++) begin
      dmg[t] = '0;
      for (int unsigned a = 0; a < NP; a++) begin
        if (melee_ov[a*NP+t]) dmg[t] = dmg[t] + DMG_W'(MELEE_DMG);
        if (fire_ov[a*NP+t])  dmg[t] = dmg[t] + DMG_W'(FIREBALL_DMG);
      end
    end
    for (int unsigned a = 0; a < NP; a++) begin
      fireball_hit_d[a] = (|fire_ov[a*NP +: NP]) && !game_over_q;
      melee_spent_d[a]  = melee_spent_q[a];
      if ((state[a] != MELEE_STATE_RIGHT) && (state[a] != MELEE_STATE_LEFT)) begin
        melee_spent_d[a] = 1'b0;
      end else if ((|melee_ov[a*NP +: NP]) && !game_over_q) begin
        melee_spent_d[a] = 1'b1;
      end
    end
  end

  for (genvar p = 0; p < NP; p++) begin : g_ch
    health_channel #(
      .HEALTH_W      (HEALTH_W),
      .DMG_W         (DMG_W),
      .MAX_HEALTH    (MAX_HEALTH),
      .INVULN_CYCLES (INVULN_CYCLES)
    ) u_health (
      .clk             (clk),
      .reset_n         (reset_n),
      .round_restart_i (round_restart),
      .dmg_i           (dmg[p]),
      .game_over_i     (game_over_q),
      .health_o        (health_cur[p]),
      .health_next_o   (health_next[p]),
      .hit_o           (player_hit[p])
    );
    assign player_health[p*HEALTH_W +: HEALTH_W] = health_cur[p];
  end

  // Game end uses the post-edge health so game_over rises on the same edge a fighter hits zero.
  always_comb begin
    any_dead  = 1'b0;
    alive_cnt = '0;
    alive_idx = '1;
    for (int unsigned p = 0; p < NP; p++) begin
      if (health_next[p] == '0) begin
        any_dead = 1'b1;
      end else begin
        alive_cnt = alive_cnt + CNT_W'(1);
        alive_idx = WIN_W'(p);
      end
    end
    game_over_d = game_over_q | any_dead;
    winner_d    = winner_q;
    if (!game_over_q && any_dead) begin
      winner_d = (alive_cnt == CNT_W'(1)) ? alive_idx : '1;
    end
  end

  // Round-level registers: swing flags, fireball pulses, game_over and winner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      melee_spent_q  <= '0;
      fireball_hit_q <= '0;
      game_over_q    <= 1'b0;
      winner_q       <= '1;
    end else if (round_restart) begin
      melee_spent_q  <= '0;
      fireball_hit_q <= '0;
      game_over_q    <= 1'b0;
      winner_q       <= '1;
    end else begin
      melee_spent_q  <= melee_spent_d;
      fireball_hit_q <= fireball_hit_d;
      game_over_q    <= game_over_d;
      winner_q       <= winner_d;
    end
  end

  assign fireball_hit = fireball_hit_q;
  assign game_over    = game_over_q;
  assign winner       = winner_q;

endmodule
